// File: rtl/boot_loader_ctrl_pkg.sv
// Shared definitions for the boot loader controller.
//   ld_state_t       : loader FSM states (length, payload, ack, run)
//   UART_*_OFS       : UART MMIO register offsets used by the core's memory stage
//   is_uart_mmio_ofs : true when an offset selects one of the UART registers
package boot_loader_ctrl_pkg;

  typedef enum logic [1:0] {
    LD_LEN,
    LD_DATA,
    LD_ACK,
    LD_RUN
  } ld_state_t;

  localparam logic [3:0] UART_RX_OFS      = 4'h0;
  localparam logic [3:0] UART_RXVALID_OFS = 4'h4;
  localparam logic [3:0] UART_TXREADY_OFS = 4'h8;
  localparam logic [3:0] UART_TX_OFS      = 4'hC;

  function automatic logic is_uart_mmio_ofs(input logic [3:0] ofs);
    return (ofs == UART_RX_OFS)      || (ofs == UART_RXVALID_OFS) ||
           (ofs == UART_TXREADY_OFS) || (ofs == UART_TX_OFS);
  endfunction

endpackage

// File: rtl/boot_loader_ctrl_byte_assembler.sv
// Packs a little-endian byte stream into 32-bit words.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : drop any partially assembled word
//   take       : byte_in is consumed this cycle
//   byte_in    : incoming byte
//   word       : assembled word, valid while word_done is high
//   word_done  : 1-cycle pulse on the cycle the 4th byte of a word is taken
// The first three bytes are held in a register; the 4th byte is merged
// combinationally so the caller can register the full word on that same edge.
module boot_loader_ctrl_byte_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  byte_cnt_q;
  logic [23:0] low_bytes_q;

  // NOTE: sequential state is updated with <= so every register samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_cnt_q  <= 2'd0;
      low_bytes_q <= 24'd0;
    end else if (take) begin
      byte_cnt_q <= byte_cnt_q + 2'd1;
      case (byte_cnt_q)
        2'd0:    low_bytes_q[7:0]   <= byte_in;
        2'd1:    low_bytes_q[15:8]  <= byte_in;
        2'd2:    low_bytes_q[23:16] <= byte_in;
        default: low_bytes_q        <= low_bytes_q;
      endcase
    end
  end

  assign word      = {byte_in, low_bytes_q};
  assign word_done = take && (byte_cnt_q == 2'd3);

endmodule

// File: rtl/boot_loader_ctrl.sv
// Boot loader controller: owns the UART rx/tx FIFOs and the imem write port
// until a program has been loaded, then becomes a transparent arbiter for
// the core's memory stage.
//   clk, rst                 : clock, synchronous active-high reset
//   reload                   : pulse in RUN to re-enter load mode
//   core_stall, loading      : pipeline hold / load-in-progress indicator
//   uart_rx_data, empty      : rx FIFO head (first-word-fall-through) and empty
//   full                     : tx FIFO full
//   uart_rd_en, uart_wr_en,
//   uart_tx_data             : arbitrated rx pop / tx push / tx data
//   core_uart_*              : memory-stage UART requests
//   core_imem*               : memory-stage imem write request
//   imem_we, imem_waddr,
//   imem_wdata               : arbitrated imem write port
// Load protocol: 32-bit little-endian word count N, then N little-endian
// words written from LOAD_BASE upward, then ACK_BYTE is pushed to tx.
module boot_loader_ctrl #(
  parameter logic [31:0] LOAD_BASE = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 16384,
  parameter logic [7:0]  ACK_BYTE  = 8'hAA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reload,
  output logic        core_stall,
  output logic        loading,
  input  logic [7:0]  uart_rx_data,
  input  logic        empty,
  input  logic        full,
  output logic        uart_rd_en,
  output logic        uart_wr_en,
  output logic [7:0]  uart_tx_data,
  input  logic        core_uart_rd_en,
  input  logic        core_uart_wr_en,
  input  logic [7:0]  core_uart_tx,
  input  logic        core_imemwrite,
  input  logic [31:0] core_imemwaddr,
  input  logic [31:0] core_imemwdata,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata
);

  import boot_loader_ctrl_pkg::*;

  ld_state_t   state_q, state_d;
  logic [31:0] n_q;
  logic [31:0] word_idx_q;
  logic        ld_we_q;
  logic [31:0] ld_waddr_q;
  logic [31:0] ld_wdata_q;

  logic        take;
  logic        asm_clear;
  logic        asm_done;
  logic [31:0] asm_word;
  logic        tx_push;
  logic        last_word;
  logic        in_range;

  boot_loader_ctrl_byte_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (asm_clear),
    .take      (take),
    .byte_in   (uart_rx_data),
    .word      (asm_word),
    .word_done (asm_done)
  );

  assign last_word = (word_idx_q == n_q - 32'd1);
  // Words beyond imem capacity are still consumed from the stream, just not written.
  assign in_range  = (word_idx_q < MAX_WORDS);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    take      = 1'b0;
    asm_clear = 1'b0;
    tx_push   = 1'b0;
    case (state_q)
      LD_LEN: begin
        take = ~empty;
        if (asm_done) state_d = (asm_word == 32'd0) ? LD_ACK : LD_DATA;
      end
      LD_DATA: begin
        take = ~empty;
        if (asm_done && last_word) state_d = LD_ACK;
      end
      LD_ACK: begin
        if (!full) begin
          tx_push = 1'b1;
          state_d = LD_RUN;
        end
      end
      LD_RUN: begin
        if (reload) begin
          asm_clear = 1'b1;
          state_d   = LD_LEN;
        end
      end
      default: state_d = LD_LEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LD_LEN;
      n_q        <= 32'd0;
      word_idx_q <= 32'd0;
      ld_we_q    <= 1'b0;
      ld_waddr_q <= 32'd0;
      ld_wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      ld_we_q <= 1'b0;
      case (state_q)
        LD_LEN: begin
          if (asm_done) begin
            n_q        <= asm_word;
            word_idx_q <= 32'd0;
          end
        end
        LD_DATA: begin
          if (asm_done) begin
            word_idx_q <= word_idx_q + 32'd1;
            if (in_range) begin
              ld_we_q    <= 1'b1;
              ld_waddr_q <= LOAD_BASE + {word_idx_q[29:0], 2'b00};
              ld_wdata_q <= asm_word;
            end
          end
        end
        LD_RUN: begin
          if (reload) begin
            n_q        <= 32'd0;
            word_idx_q <= 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output arbitration: the core owns the shared resources only in RUN;
  // elsewhere its requests are dropped while the pipeline is held.
  always_comb begin
    core_stall = (state_q != LD_RUN);
    loading    = (state_q != LD_RUN);
    if (state_q == LD_RUN) begin
      uart_rd_en   = core_uart_rd_en;
      uart_wr_en   = core_uart_wr_en;
      uart_tx_data = core_uart_tx;
      imem_we      = core_imemwrite;
      imem_waddr   = core_imemwaddr;
      imem_wdata   = core_imemwdata;
    end else begin
      uart_rd_en   = take;
      uart_wr_en   = tx_push;
      uart_tx_data = tx_push ? ACK_BYTE : 8'h00;
      imem_we      = ld_we_q;
      imem_waddr   = ld_waddr_q;
      imem_wdata   = ld_wdata_q;
    end
  end

endmodule
